// File: rtl/ram_arbiter_if.sv
// Bus bundle between two RAM requesters, the arbiter and a synchronous
// single-port RAM. The arbiter sits on the slave modport. Requesters and the
// RAM model sit on the master modport.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  // Port 0 requester
  logic                  Req0;
  logic [ADDR_WIDTH-1:0] Addr0;
  logic                  Write0;
  logic [DATA_WIDTH-1:0] WData0;
  logic                  Grant0;
  logic [DATA_WIDTH-1:0] RData0;
  logic                  Valid0;

  // Port 1 requester
  logic                  Req1;
  logic [ADDR_WIDTH-1:0] Addr1;
  logic                  Write1;
  logic [DATA_WIDTH-1:0] WData1;
  logic                  Grant1;
  logic [DATA_WIDTH-1:0] RData1;
  logic                  Valid1;

  // RAM side
  logic [ADDR_WIDTH-1:0] RamAddress;
  logic                  RamMemWrite;
  logic [DATA_WIDTH-1:0] RamWriteData;
  logic [DATA_WIDTH-1:0] RamReadData;

  modport slave (
    input  Req0, Addr0, Write0, WData0,
    output Grant0, RData0, Valid0,
    input  Req1, Addr1, Write1, WData1,
    output Grant1, RData1, Valid1,
    output RamAddress, RamMemWrite, RamWriteData,
    input  RamReadData
  );

  modport master (
    output Req0, Addr0, Write0, WData0,
    input  Grant0, RData0, Valid0,
    output Req1, Addr1, Write1, WData1,
    input  Grant1, RData1, Valid1,
    input  RamAddress, RamMemWrite, RamWriteData,
    output RamReadData
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a synchronous single-port RAM.
// Grants are combinational. When both ports contend, the port that owns the
// current run keeps the RAM for up to MAX_BURST consecutive grants (legal
// range 1..15, held in a 4-bit counter), then hands over. Reads return one
// cycle after the grant on the granted port's RData/Valid. Each port holds its
// last delivered read word while Valid is low.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic {
    Port0 = 1'b0,
    Port1 = 1'b1
  } portSel_e;

  localparam logic [3:0] BurstLimit = 4'(MAX_BURST);

  // Arbitration state
  portSel_e              LastPort;
  portSel_e              lastPortNext;
  logic [3:0]            BurstCnt;
  logic [3:0]            burstCntNext;

  // Combinational grant decision
  portSel_e              winner;
  logic                  grant0;
  logic                  grant1;
  logic                  granted;

  // RAM command for the current cycle
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic                  ramWrite;
  logic [DATA_WIDTH-1:0] ramWData;

  // Read-return stage: one cycle behind the grant, matching RAM latency
  logic                  rdVld0_p1;
  logic                  rdVld1_p1;
  logic [DATA_WIDTH-1:0] rdHeld0;
  logic [DATA_WIDTH-1:0] rdHeld1;

  function automatic portSel_e otherPort(input portSel_e p);
    return (p == Port0) ? Port1 : Port0;
  endfunction

  // Pick at most one port this cycle; nothing is granted while in reset.
  always_comb begin
    winner = Port0;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!Reset) begin
      if (bus.Req0 && !bus.Req1) begin
        grant0 = 1'b1;
      end else if (bus.Req1 && !bus.Req0) begin
        grant1 = 1'b1;
      end else if (bus.Req0 && bus.Req1) begin
        // Idle history: favour the port that did not go last.
        // Running burst: the owner keeps going until the limit is hit.
        if (BurstCnt == 4'd0) begin
          winner = otherPort(LastPort);
        end else if (BurstCnt < BurstLimit) begin
          winner = LastPort;
        end else begin
          winner = otherPort(LastPort);
        end
        grant0 = (winner == Port0);
        grant1 = (winner == Port1);
      end
    end
  end

  assign granted = grant0 | grant1;

  // Steer the granted port onto the RAM; drive zeros when idle.
  always_comb begin
    ramAddr  = '0;
    ramWrite = 1'b0;
    ramWData = '0;
    if (grant0) begin
      ramAddr  = bus.Addr0;
      ramWrite = bus.Write0;
      ramWData = bus.WData0;
    end else if (grant1) begin
      ramAddr  = bus.Addr1;
      ramWrite = bus.Write1;
      ramWData = bus.WData1;
    end
  end

  // Next LastPort / BurstCnt: burst restarts on a port switch or after idle.
  always_comb begin
    lastPortNext = LastPort;
    burstCntNext = 4'd0;
    if (granted) begin
      lastPortNext = grant1 ? Port1 : Port0;
      if ((BurstCnt == 4'd0) || (lastPortNext != LastPort)) begin
        burstCntNext = 4'd1;
      end else if (BurstCnt < BurstLimit) begin
        burstCntNext = BurstCnt + 4'd1;
      end else begin
        burstCntNext = BurstLimit;
      end
    end
  end

  // Arbitration state register; reset leaves port 1 as "last" so port 0 wins first.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      LastPort <= Port1;
      BurstCnt <= 4'd0;
    end else begin
      LastPort <= lastPortNext;
      BurstCnt <= burstCntNext;
    end
  end

  // ---- stage p0 -> p1: remember which port issued a read this cycle ----
  // Mark reads issued this cycle so the RAM word can be routed back next cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdVld0_p1 <= 1'b0;
      rdVld1_p1 <= 1'b0;
    end else begin
      rdVld0_p1 <= grant0 & ~bus.Write0;
      rdVld1_p1 <= grant1 & ~bus.Write1;
    end
  end

  // Keep the last delivered word per port so RData is stable between reads.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdHeld0 <= '0;
      rdHeld1 <= '0;
    end else begin
      if (rdVld0_p1) begin
        rdHeld0 <= bus.RamReadData;
      end
      if (rdVld1_p1) begin
        rdHeld1 <= bus.RamReadData;
      end
    end
  end

  // ---- stage p1: outputs ----
  // Reset masks everything combinationally, including a read issued the
  // cycle before reset, whose return-stage flag has not been cleared yet.
  assign bus.Grant0       = grant0;
  assign bus.Grant1       = grant1;
  assign bus.RamAddress   = ramAddr;
  assign bus.RamMemWrite  = ramWrite;
  assign bus.RamWriteData = ramWData;

  assign bus.Valid0 = rdVld0_p1 & ~Reset;
  assign bus.Valid1 = rdVld1_p1 & ~Reset;
  assign bus.RData0 = Reset ? '0 : (rdVld0_p1 ? bus.RamReadData : rdHeld0);
  assign bus.RData1 = Reset ? '0 : (rdVld1_p1 ? bus.RamReadData : rdHeld1);

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios followed by randomized
// traffic, checked every cycle against a transaction-level reference model.
module tb_ram_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busA ();
  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busB ();

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .Clock(clk), .Reset(rst), .bus(busA)
  );
  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(1)) dutB (
    .Clock(clk), .Reset(rst), .bus(busB)
  );

  // Synchronous RAM behind the main instance (16 words used)
  logic [DW-1:0] ram [0:15];
  always @(posedge clk) begin
    if (busA.RamMemWrite) ram[busA.RamAddress[3:0]] <= busA.RamWriteData;
    busA.RamReadData <= ram[busA.RamAddress[3:0]];
  end
  // Trivial read data for the MAX_BURST=1 instance
  always @(posedge clk) busB.RamReadData <= {{(DW-AW){1'b0}}, busB.RamAddress};

  int nChecks = 0;
  int nPass = 0;

  // Reference model: who owns the RAM, how long its run is, what comes back next
  int            mLast = 1;
  int            mRun = 0;
  bit            mPend0 = 0, mPend1 = 0;
  logic [DW-1:0] mPendData = '0;
  logic [DW-1:0] mHeld0 = '0, mHeld1 = '0;
  logic [DW-1:0] mMem [0:15];
  int            gPort = -1;
  int            obsG = -1;
  int            obsGB = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass = nPass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: check DUT against model at negedge, advance model after posedge.
  task automatic tick();
    int            win;
    logic [AW-1:0] eAddr;
    logic          eWr;
    logic [DW-1:0] eWd, eRd0, eRd1;
    bit            eV0, eV1;
    @(negedge clk);
    win = -1;
    if (!rst) begin
      if (busA.Req0 && !busA.Req1) win = 0;
      else if (!busA.Req0 && busA.Req1) win = 1;
      else if (busA.Req0 && busA.Req1) begin
        // a fresh contention or an exhausted run goes to the other port
        if (mRun == 0 || mRun >= MB) win = 1 - mLast;
        else win = mLast;
      end
    end
    eAddr = '0; eWr = 1'b0; eWd = '0;
    if (win == 0) begin eAddr = busA.Addr0; eWr = busA.Write0; eWd = busA.WData0; end
    if (win == 1) begin eAddr = busA.Addr1; eWr = busA.Write1; eWd = busA.WData1; end
    eV0  = !rst && mPend0;
    eV1  = !rst && mPend1;
    eRd0 = rst ? '0 : (mPend0 ? mPendData : mHeld0);
    eRd1 = rst ? '0 : (mPend1 ? mPendData : mHeld1);
    obsG  = busA.Grant1 ? 1 : (busA.Grant0 ? 0 : -1);
    obsGB = busB.Grant1 ? 1 : (busB.Grant0 ? 0 : -1);
    chk("grant0", busA.Grant0, win == 0);
    chk("grant1", busA.Grant1, win == 1);
    chk("ramAddress", busA.RamAddress, eAddr);
    chk("ramMemWrite", busA.RamMemWrite, eWr);
    chk("ramWriteData", busA.RamWriteData, eWd);
    chk("valid0", busA.Valid0, eV0);
    chk("valid1", busA.Valid1, eV1);
    chk("rdata0", busA.RData0, eRd0);
    chk("rdata1", busA.RData1, eRd1);
    chk("grantB_onehot", busB.Grant0 & busB.Grant1, 1'b0);
    @(posedge clk);
    #1;
    gPort = win;
    if (rst) begin
      mLast = 1; mRun = 0; mPend0 = 0; mPend1 = 0; mHeld0 = '0; mHeld1 = '0;
    end else begin
      if (mPend0) mHeld0 = mPendData;
      if (mPend1) mHeld1 = mPendData;
      mPend0 = 0; mPend1 = 0;
      if (win >= 0) begin
        if (eWr) mMem[eAddr[3:0]] = eWd;
        else begin
          mPendData = mMem[eAddr[3:0]];
          if (win == 0) mPend0 = 1; else mPend1 = 1;
        end
        mRun  = (mRun == 0 || win != mLast) ? 1 : ((mRun + 1 > MB) ? MB : mRun + 1);
        mLast = win;
      end else begin
        mRun = 0;
      end
    end
  endtask

  task automatic drive0(input logic rq, input logic wr, input int addr, input logic [DW-1:0] d);
    busA.Req0 = rq; busA.Write0 = wr; busA.Addr0 = AW'(addr); busA.WData0 = d;
  endtask

  task automatic drive1(input logic rq, input logic wr, input int addr, input logic [DW-1:0] d);
    busA.Req1 = rq; busA.Write1 = wr; busA.Addr1 = AW'(addr); busA.WData1 = d;
  endtask

  // Run until every pending request has been granted, then one more cycle for read return.
  task automatic drain();
    int n;
    n = 0;
    while ((busA.Req0 || busA.Req1) && n < 20) begin
      tick();
      if (gPort == 0) busA.Req0 = 1'b0;
      if (gPort == 1) busA.Req1 = 1'b0;
      n++;
    end
    chk("drain_bound", {busA.Req0, busA.Req1}, 2'b00);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat26 [10];
    pat26 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 16; i++) mMem[i] = '0;
    rst = 1'b1;
    drive0(1'b0, 1'b0, 0, '0);
    drive1(1'b0, 1'b0, 0, '0);
    busB.Req0 = 1'b0; busB.Addr0 = '0; busB.Write0 = 1'b0; busB.WData0 = '0;
    busB.Req1 = 1'b0; busB.Addr1 = '0; busB.Write1 = 1'b0; busB.WData1 = '0;

    // Reset state
    tick();
    tick();
    chk("rst_lastport", dut.LastPort, 1'b1);
    chk("rst_burstcnt", dut.BurstCnt, 4'd0);
    rst = 1'b0;

    // Fill RAM through port 0; addr 0 and 1 get the interleave patterns
    for (int i = 0; i < 16; i++) begin
      drive0(1'b1, 1'b1, i, (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'h7FFF_FFFF : $urandom);
      drain();
    end

    // Single port write then read of address 3
    drive0(1'b1, 1'b1, 3, 32'h0000_0007);
    tick();
    chk("sp_wgrant", obsG, 0);
    drive0(1'b1, 1'b0, 3, '0);
    tick();
    chk("sp_rgrant", obsG, 0);
    busA.Req0 = 1'b0;
    tick();
    chk("sp_rdata", busA.RData0, 32'h0000_0007);

    // Contention after reset, MAX_BURST=4
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    drive0(1'b1, 1'b0, 5, '0);
    drive1(1'b1, 1'b0, 6, '0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("contention_seq", obsG, pat26[i]);
    end
    busA.Req0 = 1'b0;
    busA.Req1 = 1'b0;
    tick();

    // Interleaved reads of addresses 0 and 1
    drive0(1'b1, 1'b0, 0, '0);
    drive1(1'b1, 1'b0, 1, '0);
    drain();
    chk("interleave_rdata0", busA.RData0, 32'hFFFF_FFFF);
    chk("interleave_rdata1", busA.RData1, 32'h7FFF_FFFF);

    // Write on port 1, then read-after-write on port 0
    drive1(1'b1, 1'b1, 2, 32'h0000_0001);
    tick();
    chk("raw_wgrant", obsG, 1);
    busA.Req1 = 1'b0;
    drive0(1'b1, 1'b0, 2, '0);
    tick();
    chk("raw_rgrant", obsG, 0);
    busA.Req0 = 1'b0;
    tick();
    chk("raw_rdata0", busA.RData0, 32'h0000_0001);

    // Reset in the cycle after a read grant
    drive0(1'b1, 1'b0, 3, '0);
    tick();
    busA.Req0 = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("midrst_lastport", dut.LastPort, 1'b1);
    chk("midrst_burstcnt", dut.BurstCnt, 4'd0);
    rst = 1'b0;
    drive0(1'b1, 1'b0, 4, '0);
    drive1(1'b1, 1'b0, 5, '0);
    tick();
    chk("midrst_first", obsG, 0);
    if (gPort == 0) busA.Req0 = 1'b0;
    drain();

    // Idle: burst counter stays cleared
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_burstcnt", dut.BurstCnt, 4'd0);
    end

    // MAX_BURST=1 instance alternates under contention
    busB.Req0 = 1'b1;
    busB.Req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mb1_alternate", obsGB, i % 2);
    end
    busB.Req0 = 1'b0;
    busB.Req1 = 1'b0;

    // Randomized traffic with hold-until-grant and occasional reset
    for (int i = 0; i < 400; i++) begin
      tick();
      if (rst) rst = 1'b0;
      else rst = ($urandom_range(0, 99) == 0);
      if (!busA.Req0 || gPort == 0)
        drive0($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
      if (!busA.Req1 || gPort == 1)
        drive1($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
    end
    rst = 1'b0;
    drive0(1'b0, 1'b0, 0, '0);
    drive1(1'b0, 1'b0, 0, '0);
    tick();
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 14, RAM word-address width.
REQ-002 Parameter: DATA_WIDTH, 32, RAM data width.
REQ-003 Parameter: MAX_BURST, 4, max consecutive grants to one port while the other port waits; legal range 1..15.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports: Clock  in  1  rising-edge clock; Reset  in  1  synchronous active-high reset.
REQ-006 Ports: Req0  in  1  port-0 request; Addr0  in  ADDR_WIDTH  address; Write0  in  1  1=write, 0=read; WData0  in  DATA_WIDTH  write data.
REQ-007 Ports: Grant0  out  1  access accepted this cycle; RData0  out  DATA_WIDTH  read data; Valid0  out  1  RData0 valid.
REQ-008 Ports: Req1, Addr1, Write1, WData1, Grant1, RData1, Valid1: port 1, identical widths and meaning.
REQ-009 Ports: RamAddress  out  ADDR_WIDTH; RamMemWrite  out  1; RamWriteData  out  DATA_WIDTH; RamReadData  in  DATA_WIDTH. Connect to the RAM's Address, MemWrite, WriteData and ReadData.

Function
REQ-010 The RAM SHALL be treated as synchronous: a write commits at the rising edge where RamMemWrite=1. Read data appears on RamReadData in the cycle after the address is presented.
REQ-011 At most one of Grant0/Grant1 SHALL be high in any cycle. Grants are combinational from Req*, LastPort and BurstCnt.
REQ-012 A transaction SHALL occur in the cycle its Grant is high. The requester holds Req/Addr/Write/WData stable until it sees Grant, then may change them at the next edge.
REQ-013 In a granted cycle, RamAddress, RamMemWrite and RamWriteData SHALL equal the granted port's Addr, Write and WData. With no grant: RamMemWrite=0, RamAddress=0, RamWriteData=0.
REQ-014 Only one port requesting: that port SHALL be granted regardless of history.
REQ-015 Both ports requesting, with the previous cycle idle or LastPort undefined: grant the port not equal to LastPort.
REQ-016 Both ports requesting, with the previous cycle granted to port P: continue granting P while BurstCnt<MAX_BURST. Grant the other port when BurstCnt==MAX_BURST.
REQ-017 State registers:
 - LastPort (1 bit): port of the most recent grant; updated only on granted cycles.
 - BurstCnt (4 bits): 1 on a grant that switches port or follows an idle cycle; +1 on a repeat grant, saturating at MAX_BURST; 0 on an idle cycle.
REQ-018 A granted read SHALL set Valid<p>=1 for exactly one cycle, the cycle after the grant, with RData<p>=RamReadData in that cycle. Granted writes produce no Valid.
REQ-019 Back-to-back reads SHALL be fully pipelined: one grant per cycle, Valid in every following cycle, returned in grant order, each routed to its own port.
REQ-020 RData0/RData1 SHALL hold their last delivered value when Valid is low.
REQ-021 Read-after-write to the same address in consecutive granted cycles SHALL return the newly written data. The arbiter adds no bypass; ordering follows from REQ-010.

Reset
REQ-022 While Reset=1: Grant0=Grant1=0, RamMemWrite=0, RamAddress=0, RamWriteData=0, Valid0=Valid1=0, RData0=RData1=0, LastPort=1, BurstCnt=0.
REQ-023 A read granted in the cycle before Reset is asserted SHALL NOT produce a Valid pulse. No RAM write SHALL occur in any cycle with Reset=1.
REQ-024 In the first cycle after Reset deasserts with both Req high, port 0 SHALL be granted (REQ-015, LastPort=1).

Verification
REQ-025 Single port: port 0 writes 32'h0000_0007 to address 3, then reads address 3 -> Grant0 in both cycles; Valid0=1 with RData0=32'h0000_0007 one cycle after the read grant; Valid1 never high.
REQ-026 Contention, MAX_BURST=4: both ports hold Req=1 for reads, continuously for 10 cycles after reset -> grant sequence 0,0,0,0,1,1,1,1,0,0. Valid follows each grant by one cycle on the matching port.
REQ-027 Interleave: port 0 reads address 0 (preloaded 32'hFFFF_FFFF) while port 1 reads address 1 (preloaded 32'h7FFF_FFFF), both requesting in the same cycle -> RData0=32'hFFFF_FFFF and RData1=32'h7FFF_FFFF, one cycle apart, never swapped.
REQ-028 Write/read hazard: port 1 writes 32'h1 to address 2, and port 0 reads address 2 in the next granted cycle -> RData0=32'h0000_0001.
REQ-029 Reset mid-read: port 0 is granted a read at cycle N and Reset=1 at cycle N+1 -> Valid0=0 at N+1; all outputs match REQ-022; after release, both Req high -> Grant0 first.
REQ-030 Idle and MAX_BURST=1: with no Req, RamMemWrite=0 and BurstCnt=0 every cycle. With MAX_BURST=1 and both ports requesting, grants alternate 0,1,0,1.
